// File: rtl/icache_ctrl.sv
// ---------------------------------------------------------------------------
// icache_ctrl
//   Direct-mapped, read-only instruction cache between the fetch port and the
//   instruction memory. Hits return one cycle after acceptance; misses fetch a
//   whole 4-word line over a req/ack handshake and return the requested word
//   on the ack edge. Saturating hit/miss counters support perf reporting.
//
// Ports
//   clk, reset_n    clock, synchronous active-low reset
//   cpu_req/addr    fetch request and word address
//   cpu_ready/rdata one-cycle data-valid pulse and fetched instruction
//   cpu_busy        high while a line fill is outstanding
//   flush           invalidate all lines (deferred to fill end if in FILL)
//   mem_req/addr    line-fill request (held until ack), line-aligned address
//   mem_ack/rdata   one-cycle ack with the full line (word0 in the LSBs)
//   hit_cnt/miss_cnt saturating counts of accepted hits and misses
// ---------------------------------------------------------------------------
module icache_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_req,
  input  logic [WORD_SIZE-1:0]   cpu_addr,
  output logic                   cpu_ready,
  output logic [WORD_SIZE-1:0]   cpu_rdata,
  output logic                   cpu_busy,
  input  logic                   flush,
  output logic                   mem_req,
  output logic [WORD_SIZE-1:0]   mem_addr,
  input  logic                   mem_ack,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0]   hit_cnt,
  output logic [WORD_SIZE-1:0]   miss_cnt
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = WORD_SIZE - INDEX_BITS - 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    end
  endfunction

  // Select one word out of a packed 4-word line.
  function automatic logic [WORD_SIZE-1:0] line_word(input logic [4*WORD_SIZE-1:0] line,
                                                     input logic [1:0]             off);
    case (off)
      2'd0:    line_word = line[0*WORD_SIZE +: WORD_SIZE];
      2'd1:    line_word = line[1*WORD_SIZE +: WORD_SIZE];
      2'd2:    line_word = line[2*WORD_SIZE +: WORD_SIZE];
      2'd3:    line_word = line[3*WORD_SIZE +: WORD_SIZE];
      default: line_word = {WORD_SIZE{1'b0}};
    endcase
  endfunction

  // State and registered outputs
  state_e                 state_q, state_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic                   flush_pending_q, flush_pending_d;
  logic [WORD_SIZE-1:0]   addr_q, addr_d;
  logic                   cpu_ready_q, cpu_ready_d;
  logic [WORD_SIZE-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                   mem_req_q, mem_req_d;
  logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]   hit_cnt_q, hit_cnt_d;
  logic [WORD_SIZE-1:0]   miss_cnt_q, miss_cnt_d;

  // Arrays: deliberately not reset, validity is tracked by valid_q alone
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [WORD_SIZE-1:0]   data_q [LINES][4];

  // Address fields of the incoming request and of the latched (filling) one
  logic [1:0]             req_off_s;
  logic [INDEX_BITS-1:0]  req_idx_s;
  logic [TAG_W-1:0]       req_tag_s;
  logic [1:0]             fill_off_s;
  logic [INDEX_BITS-1:0]  fill_idx_s;
  logic [TAG_W-1:0]       fill_tag_s;
  logic                   hit_s;
  logic                   fill_done_s;

  assign req_off_s   = cpu_addr[1:0];
  assign req_idx_s   = cpu_addr[INDEX_BITS+1:2];
  assign req_tag_s   = cpu_addr[WORD_SIZE-1:INDEX_BITS+2];
  assign fill_off_s  = addr_q[1:0];
  assign fill_idx_s  = addr_q[INDEX_BITS+1:2];
  assign fill_tag_s  = addr_q[WORD_SIZE-1:INDEX_BITS+2];
  assign hit_s       = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  assign fill_done_s = (state_q == ST_FILL) && mem_ack;

  // Next-state and next-output computation for the IDLE/FILL controller
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    flush_pending_d = flush_pending_q;
    addr_d          = addr_q;
    cpu_ready_d     = 1'b0;
    cpu_rdata_d     = cpu_rdata_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;

    case (state_q)
      ST_IDLE: begin
        mem_req_d = 1'b0;
        if (flush) begin
          // Flush wins over a simultaneous request; the request is dropped.
          valid_d = {LINES{1'b0}};
        end else if (cpu_req) begin
          if (hit_s) begin
            cpu_rdata_d = data_q[req_idx_s][req_off_s];
            cpu_ready_d = 1'b1;
            hit_cnt_d   = sat_inc(hit_cnt_q);
          end else begin
            addr_d      = cpu_addr;
            state_d     = ST_FILL;
            mem_req_d   = 1'b1;
            mem_addr_d  = {cpu_addr[WORD_SIZE-1:2], 2'b00};
            miss_cnt_d  = sat_inc(miss_cnt_q);
          end
        end else begin
          cpu_ready_d = 1'b0;
        end
      end

      ST_FILL: begin
        if (mem_ack) begin
          cpu_rdata_d = line_word(mem_rdata, fill_off_s);
          cpu_ready_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = ST_IDLE;
          // A flush seen at any point during the fill also kills the new line.
          if (flush_pending_q || flush) begin
            valid_d = {LINES{1'b0}};
          end else begin
            valid_d[fill_idx_s] = 1'b1;
          end
          flush_pending_d = 1'b0;
        end else if (flush) begin
          flush_pending_d = 1'b1;
        end else begin
          flush_pending_d = flush_pending_q;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Controller registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      valid_q         <= {LINES{1'b0}};
      flush_pending_q <= 1'b0;
      addr_q          <= {WORD_SIZE{1'b0}};
      cpu_ready_q     <= 1'b0;
      cpu_rdata_q     <= {WORD_SIZE{1'b0}};
      mem_req_q       <= 1'b0;
      mem_addr_q      <= {WORD_SIZE{1'b0}};
      hit_cnt_q       <= {WORD_SIZE{1'b0}};
      miss_cnt_q      <= {WORD_SIZE{1'b0}};
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      flush_pending_q <= flush_pending_d;
      addr_q          <= addr_d;
      cpu_ready_q     <= cpu_ready_d;
      cpu_rdata_q     <= cpu_rdata_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
    end
  end

  // Tag/data array write on fill completion (reset only gates the write)
  always_ff @(posedge clk) begin
    if (reset_n && fill_done_s) begin
      tag_q[fill_idx_s]        <= fill_tag_s;
      data_q[fill_idx_s][2'd0] <= mem_rdata[0*WORD_SIZE +: WORD_SIZE];
      data_q[fill_idx_s][2'd1] <= mem_rdata[1*WORD_SIZE +: WORD_SIZE];
      data_q[fill_idx_s][2'd2] <= mem_rdata[2*WORD_SIZE +: WORD_SIZE];
      data_q[fill_idx_s][2'd3] <= mem_rdata[3*WORD_SIZE +: WORD_SIZE];
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_busy  = (state_q == ST_FILL);
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction cache between the pipeline fetch port and instruction memory.
- It replaces the fixed one-cycle fetch stall with a real hit/miss model.
- Hits return in 1 cycle. Misses fetch a full 4-word line over a req/ack memory handshake.
- Hit and miss counters are kept for performance reporting.

Parameters:
- WORD_SIZE, 16, width of address and data words
- INDEX_BITS, 2, number of lines is 2**INDEX_BITS (4 lines)
- Offset is fixed at 2 bits (4 words per line). Tag width = WORD_SIZE-INDEX_BITS-2 (12).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  fetch request
- cpu_addr  in  WORD_SIZE  word address of the fetch
- cpu_ready  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  WORD_SIZE  fetched instruction
- cpu_busy  out  1  high while state is FILL (request not accepted)
- flush  in  1  invalidate all lines
- mem_req  out  1  line-fill request, held until ack
- mem_addr  out  WORD_SIZE  line-aligned address {tag,index,2'b00}
- mem_ack  in  1  one-cycle: mem_rdata valid
- mem_rdata  in  4*WORD_SIZE  line data; word0 in bits [15:0], word3 in [63:48]
- hit_cnt  out  WORD_SIZE  accepted hits, saturating
- miss_cnt  out  WORD_SIZE  accepted misses, saturating

Behaviour:
- Reset (edge with reset_n=0), regardless of state:
  - all valid bits 0, state IDLE, flush_pending 0
  - cpu_ready 0, cpu_rdata 0, mem_req 0, mem_addr 0, hit_cnt 0, miss_cnt 0
  - tag/data arrays are not cleared
- Address split: offset=cpu_addr[1:0], index=cpu_addr[2+INDEX_BITS-1:2], tag=remaining upper bits.
- Hit: valid[index] && tag_array[index]==tag, evaluated combinationally in IDLE.
- States: IDLE, FILL.
- IDLE, flush=1: all valid bits cleared at the edge. cpu_req is not accepted that cycle (flush has priority).
- IDLE, cpu_req=1, hit, accept edge T:
  - cpu_rdata <= data[index][offset], cpu_ready <= 1, hit_cnt++
  - stay IDLE
  - back-to-back hits give 1 word/cycle
- IDLE, cpu_req=1, miss, accept edge T:
  - latch addr, state <= FILL, mem_req <= 1, mem_addr <= line address, miss_cnt++, cpu_ready <= 0
- IDLE, cpu_req=0: cpu_ready <= 0.
- FILL:
  - mem_req held 1 and mem_addr held stable; cpu_req ignored; cpu_busy=1
  - on mem_ack edge: write mem_rdata into data[index], tag_array[index] <= tag, valid[index] <= 1
  - at the same edge: cpu_rdata <= requested word from mem_rdata, cpu_ready <= 1, mem_req <= 0, state <= IDLE
  - miss latency = accept edge to ack edge + 1 cycle
- flush during FILL: sets flush_pending. At the mem_ack edge all valid bits are cleared, including the line just filled. cpu_ready/cpu_rdata are still returned normally. flush_pending is then cleared.
- mem_ack in IDLE is ignored.
- Reset mid-FILL aborts the fill. A later stray mem_ack is ignored.
- Counters saturate at 16'hFFFF and do not wrap. Flush does not clear counters.
- cpu_ready is exactly one cycle wide per accepted request. The CPU may present a new request in the cycle cpu_ready is high.

Test Plan:
- Reset, then cpu_req addr 0x0012, mem_ack 3 cycles later with line {0x4444,0x3333,0x2222,0x1111} -> mem_addr=0x0010, mem_req high 3 cycles, cpu_ready with cpu_rdata=0x3333, miss_cnt=1.
- After fill, back-to-back requests 0x0010,0x0011,0x0013 -> cpu_ready on 3 consecutive cycles with 0x1111,0x2222,0x4444, no mem_req, hit_cnt=3.
- Conflict: fill 0x0010, then request 0x0050 (same index, tag differs) -> miss with mem_addr=0x0050. Re-request 0x0010 -> miss again, miss_cnt=3.
- Flush in IDLE simultaneous with cpu_req on a cached address -> request not accepted, no cpu_ready. Next request to that address is a miss.
- Flush asserted during FILL -> data still returned at ack. Immediate re-request of the same address misses.
- reset_n low during FILL, then mem_ack -> mem_req 0, cpu_ready stays 0, counters 0. Preload hit_cnt to 0xFFFF via hits -> one further hit leaves it at 0xFFFF.
